host_bus_master: RTL

Bus initiator for the FPGA host register bus: it turns a simple valid/ready request into one asynchronous-SRAM-style bus cycle on HOST_nCS/HOST_nOE/HOST_nWE/HOST_ADD/HDI, and returns the read data sampled from HDO. It sits on the initiator side of the host bus. Uses: self-test sequencers, and bench-side stimulus toward register-mapped peripherals (CLCD, LED, 7-segment, dot matrix, push-button and DIP registers). One transaction in flight; setup, strobe, hold and turnaround lengths are parameterised.

---
 rtl/host_bus_master.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/host_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : host_bus_master
// Brief    : Valid/ready request to one async-SRAM-style host bus cycle.
//            Define HOST_BUS_WAIT_EN to add HOST_nWAIT strobe extension.
// Revision : 1.0 - initial release
// ============================================================================
module host_bus_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int TURN_CYC   = 1
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [20:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        HOST_nCS,
    output logic        HOST_nOE,
    output logic        HOST_nWE,
    output logic [20:0] HOST_ADD,
    output logic [15:0] HDI,
    input  logic [15:0] HDO
`ifdef HOST_BUS_WAIT_EN
    ,
    input  logic        HOST_nWAIT
`endif
);

    // Counter reload values are (effective length - 1) after clamping.
    localparam logic [15:0] c_setup_ld  = 16'((SETUP_CYC  < 1) ? 0 : SETUP_CYC  - 1);
    localparam logic [15:0] c_strobe_ld = 16'((STROBE_CYC < 2) ? 1 : STROBE_CYC - 1);
    localparam logic [15:0] c_hold_ld   = 16'((HOLD_CYC   < 1) ? 0 : HOLD_CYC   - 1);
    localparam logic [15:0] c_turn_ld   = 16'((TURN_CYC   < 1) ? 0 : TURN_CYC   - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_TURN   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [15:0] r_count;
    logic [15:0] w_count_nx;
    logic        r_write;
    logic        r_ncs;
    logic        r_noe;
    logic        r_nwe;
    logic        r_rsp_valid;
    logic        r_busy;
    logic        r_ready;
    logic [20:0] r_add;
    logic [15:0] r_hdi;
    logic [15:0] r_rdata;
    logic        w_cnt_zero;
    logic        w_wait_ok;
    logic        w_accept;
    logic        w_capture;
    logic        w_ncs_nx;
    logic        w_noe_nx;
    logic        w_nwe_nx;
    logic        w_rsp_valid_nx;

`ifdef HOST_BUS_WAIT_EN
    assign w_wait_ok = HOST_nWAIT;
`else
    assign w_wait_ok = 1'b1;
`endif

    assign w_cnt_zero = (r_count == 16'd0);

    always_comb begin
        w_state_nx     = r_state;
        w_count_nx     = r_count;
        w_accept       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_SETUP;
                    w_count_nx = c_setup_ld;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nx = S_STROBE;
                    w_count_nx = c_strobe_ld;
                end else begin
                    w_count_nx = r_count - 16'd1;
                end
            end
            S_STROBE: begin
                // Count parks at zero while the responder holds off with nWAIT.
                if (!w_cnt_zero) begin
                    w_count_nx = r_count - 16'd1;
                end else if (w_wait_ok) begin
                    w_state_nx = S_HOLD;
                    w_count_nx = c_hold_ld;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nx = S_TURN;
                    w_count_nx = c_turn_ld;
                end else begin
                    w_count_nx = r_count - 16'd1;
                end
            end
            S_TURN: begin
                if (w_cnt_zero) begin
                    w_state_nx = S_IDLE;
                    w_count_nx = 16'd0;
                end else begin
                    w_count_nx = r_count - 16'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_count_nx = 16'd0;
            end
        endcase

        // Bus levels follow the state being entered so they change on the same edge.
        w_ncs_nx       = !(w_state_nx inside {S_SETUP, S_STROBE, S_HOLD});
        w_noe_nx       = !((w_state_nx == S_STROBE) && !r_write);
        w_nwe_nx       = !((w_state_nx == S_STROBE) && r_write);
        w_rsp_valid_nx = (r_state == S_HOLD) && (w_state_nx == S_TURN);
        w_capture      = (r_state == S_STROBE) && (w_state_nx == S_HOLD) && !r_write;
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= S_IDLE;
            r_count     <= 16'd0;
            r_write     <= 1'b0;
            r_ncs       <= 1'b1;
            r_noe       <= 1'b1;
            r_nwe       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_add       <= 21'd0;
            r_hdi       <= 16'd0;
            r_rdata     <= 16'd0;
        end else begin
            r_state     <= w_state_nx;
            r_count     <= w_count_nx;
            r_ncs       <= w_ncs_nx;
            r_noe       <= w_noe_nx;
            r_nwe       <= w_nwe_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_busy      <= (w_state_nx != S_IDLE);
            r_ready     <= (w_state_nx == S_IDLE);
            if (w_accept) begin
                r_write <= req_write;
                r_add   <= req_addr;
                if (req_write) begin
                    r_hdi <= req_wdata;
                end
            end
            if (w_capture) begin
                r_rdata <= HDO;
            end
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign HOST_nCS  = r_ncs;
    assign HOST_nOE  = r_noe;
    assign HOST_nWE  = r_nwe;
    assign HOST_ADD  = r_add;
    assign HDI       = r_hdi;

endmodule
`default_nettype wire
